// File: rtl/mna_request_packetizer.sv
// NoC request packetizer: DEPTH-entry request FIFO, round-robin VC pick, flit serialiser.
// Optional statistics counters enabled by defining MNA_REQ_STATS_EN.
module mna_request_packetizer #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] header,
  input  logic [FLIT_W-1:0] body,
  input  logic [FLIT_W-1:0] tail,
  input  logic              avalid,
  input  logic              awrite,
  output logic              aready,
  input  logic              wvalid,
  output logic              wready,
  output logic [FLIT_W-1:0] noc_data,
  output logic              is_valid,
  output logic [NUM_VC-1:0] noc_vc,
  input  logic [NUM_VC-1:0] is_on_off,
  input  logic [NUM_VC-1:0] is_allocatable
`ifdef MNA_REQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef struct packed {
    logic [FLIT_W-1:0] hdr;
    logic [FLIT_W-1:0] bdy;
    logic [FLIT_W-1:0] tl;
    logic              wr;
  } req_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

  req_t              mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  state_t            state_q, state_d;
  logic [FLIT_W-1:0] noc_data_q, noc_data_d;
  logic              is_valid_q, is_valid_d;
  logic [NUM_VC-1:0] noc_vc_q, noc_vc_d;
  logic [VW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              full, empty, push, pop, stall;
  req_t              head_req;
  logic [FLIT_W-1:0] cur_flit;
  logic              go;

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign aready   = !full && avalid && (!awrite || wvalid);
  assign wready   = aready && awrite;
  assign push     = aready;
  assign head_req = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {header, (awrite ? body : '0), tail, awrite};
  end

  // Round-robin: rotate the doubled mask so the search starts at rr_ptr.
  logic [2*NUM_VC-1:0] alloc2;
  logic [NUM_VC-1:0]   rot;
  logic [VW:0]         off, sel_w, nxt_w;
  logic [VW-1:0]       sel;

  always_comb begin
    alloc2 = {is_allocatable, is_allocatable};
    rot    = alloc2[rr_ptr_q +: NUM_VC];
    off    = '0;
    for (int j = NUM_VC - 1; j >= 0; j--) begin
      if (rot[j]) off = (VW+1)'(j);
    end
    sel_w = {1'b0, rr_ptr_q} + off;
    if (sel_w >= (VW+1)'(NUM_VC)) sel_w = sel_w - (VW+1)'(NUM_VC);
    sel   = sel_w[VW-1:0];
    nxt_w = {1'b0, sel} + (VW+1)'(1);
    if (nxt_w == (VW+1)'(NUM_VC)) nxt_w = '0;
  end

  assign go = |(is_on_off & noc_vc_q);

  always_comb begin
    case (state_q)
      HEAD:    cur_flit = head_req.hdr;
      BODY:    cur_flit = head_req.bdy;
      default: cur_flit = head_req.tl;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    noc_data_d = noc_data_q;
    is_valid_d = 1'b0;
    noc_vc_d   = noc_vc_q;
    rr_ptr_d   = rr_ptr_q;
    pop        = 1'b0;
    stall      = 1'b0;
    if (state_q == IDLE) begin
      if (!empty && |is_allocatable) begin
        noc_vc_d = NUM_VC'(1) << sel;
        rr_ptr_d = nxt_w[VW-1:0];
        state_d  = HEAD;
      end
    end else if (go) begin
      noc_data_d = cur_flit;
      is_valid_d = 1'b1;
      case (state_q)
        HEAD:    state_d = head_req.wr ? BODY : TAIL;
        BODY:    state_d = TAIL;
        default: begin
          state_d = IDLE;
          pop     = 1'b1;
        end
      endcase
    end else begin
      stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      noc_data_q <= '0;
      is_valid_q <= 1'b0;
      noc_vc_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      state_q    <= state_d;
      noc_data_q <= noc_data_d;
      is_valid_q <= is_valid_d;
      noc_vc_q   <= noc_vc_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign noc_data = noc_data_q;
  assign is_valid = is_valid_q;
  assign noc_vc   = noc_vc_q;

`ifdef MNA_REQ_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)   pkt_cnt_q   <= pkt_cnt_q + CNT_W'(1);
      if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule
